operand_fetch: RTL and testbench

- Register-read pipeline stage between decode and execute.
- Consumes decoded source/destination indices over a valid/ready handshake.
- Drives the register file's two read-address ports and samples the returned data.
- Bypasses same-cycle writeback data, tracks pending writers in a scoreboard, and stalls on RAW/WAW hazards.
- Presents operands to execute through a registered valid/ready output (1-cycle latency).

---
 rtl/operand_fetch_pkg.sv | 11 +
 rtl/op_scoreboard.sv | 53 +++++
 rtl/operand_fetch.sv | 125 ++++++++++++
 tb/tb_operand_fetch.sv | 262 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/operand_fetch_pkg.sv
// Shared constants for the operand fetch stage and its scoreboard.
// Widths here are defaults only; the modules take them as overridable parameters.
package operand_fetch_pkg;

  localparam int unsigned DEF_XLEN = 32;
  localparam int unsigned DEF_AW   = 5;

  // Architectural zero register; never pending, never bypassed.
  localparam int unsigned REG_ZERO = 0;

endpackage

// File: rtl/op_scoreboard.sv
// Pending-writer scoreboard: one busy bit per architectural register.
// Set on issue, cleared on writeback, wiped on flush; a same-edge set beats a clear.
module op_scoreboard
  import operand_fetch_pkg::*;
#(
  parameter int unsigned AW = DEF_AW
) (
  input  logic              clk_i,
  input  logic              rst_ni,
  input  logic              flush_i,
  input  logic              set_i,
  input  logic [AW-1:0]     set_idx_i,
  input  logic              clr_i,
  input  logic [AW-1:0]     clr_idx_i,
  input  logic [AW-1:0]     q1_idx_i,
  output logic              q1_busy_o,
  input  logic [AW-1:0]     q2_idx_i,
  output logic              q2_busy_o,
  output logic [2**AW-1:0]  busy_o
);

  localparam logic [AW-1:0] Zero = AW'(REG_ZERO);

  logic [2**AW-1:0] busy_d, busy_q;

  always_comb begin
    busy_d = busy_q;
    if (clr_i && (clr_idx_i != Zero)) begin
      busy_d[clr_idx_i] = 1'b0;
    end
    // Applied after the clear so a new writer issued on the writeback edge stays pending.
    if (set_i && (set_idx_i != Zero)) begin
      busy_d[set_idx_i] = 1'b1;
    end
    if (flush_i) begin
      busy_d = '0;
    end
    busy_d[REG_ZERO] = 1'b0;
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      busy_q <= '0;
    end else begin
      busy_q <= busy_d;
    end
  end

  assign q1_busy_o = busy_q[q1_idx_i];
  assign q2_busy_o = busy_q[q2_idx_i];
  assign busy_o    = busy_q;

endmodule

// File: rtl/operand_fetch.sv
// Register-read stage: reads the register file, bypasses same-edge writeback,
// stalls on RAW/WAW against pending writers and registers operands for execute.
module operand_fetch
  import operand_fetch_pkg::*;
#(
  parameter int unsigned XLEN = DEF_XLEN,
  parameter int unsigned AW   = DEF_AW
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            flush,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [AW-1:0]   in_rs1,
  input  logic [AW-1:0]   in_rs2,
  input  logic [AW-1:0]   in_rd,
  input  logic            in_rd_we,
  output logic [AW-1:0]   rf_addr1,
  output logic [AW-1:0]   rf_addr2,
  input  logic [XLEN-1:0] rf_rd1,
  input  logic [XLEN-1:0] rf_rd2,
  input  logic            wb_we,
  input  logic [AW-1:0]   wb_addr,
  input  logic [XLEN-1:0] wb_data,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [XLEN-1:0] out_rs1_val,
  output logic [XLEN-1:0] out_rs2_val,
  output logic [AW-1:0]   out_rd,
  output logic            out_rd_we
);

  localparam logic [AW-1:0] Zero = AW'(REG_ZERO);

  logic            wb_hit1, wb_hit2, wb_hit_rd;
  logic            busy1, busy2;
  logic [2**AW-1:0] busy_vec;
  logic            hazard1, hazard2, waw;
  logic            accept, sb_set;
  logic [XLEN-1:0] src1_val, src2_val;

  logic            out_valid_d, out_valid_q;
  logic [XLEN-1:0] out_rs1_val_d, out_rs1_val_q;
  logic [XLEN-1:0] out_rs2_val_d, out_rs2_val_q;
  logic [AW-1:0]   out_rd_d, out_rd_q;
  logic            out_rd_we_d, out_rd_we_q;

  assign rf_addr1 = in_rs1;
  assign rf_addr2 = in_rs2;

  // The register file is written on the same edge this stage captures, so take wb data directly.
  assign wb_hit1   = wb_we && (wb_addr == in_rs1) && (in_rs1 != Zero);
  assign wb_hit2   = wb_we && (wb_addr == in_rs2) && (in_rs2 != Zero);
  assign wb_hit_rd = wb_we && (wb_addr == in_rd) && (in_rd != Zero);

  assign src1_val = wb_hit1 ? wb_data : rf_rd1;
  assign src2_val = wb_hit2 ? wb_data : rf_rd2;

  op_scoreboard #(
    .AW (AW)
  ) u_scoreboard (
    .clk_i     (clk),
    .rst_ni    (rst_n),
    .flush_i   (flush),
    .set_i     (sb_set),
    .set_idx_i (in_rd),
    .clr_i     (wb_we),
    .clr_idx_i (wb_addr),
    .q1_idx_i  (in_rs1),
    .q1_busy_o (busy1),
    .q2_idx_i  (in_rs2),
    .q2_busy_o (busy2),
    .busy_o    (busy_vec)
  );

  assign hazard1 = (in_rs1 != Zero) && busy1 && !wb_hit1;
  assign hazard2 = (in_rs2 != Zero) && busy2 && !wb_hit2;
  assign waw     = in_rd_we && (in_rd != Zero) && busy_vec[in_rd] && !wb_hit_rd;

  assign in_ready = (!out_valid_q || out_ready) && !hazard1 && !hazard2 && !waw && !flush;
  assign accept   = in_valid && in_ready;
  assign sb_set   = accept && in_rd_we && (in_rd != Zero);

  always_comb begin
    out_valid_d   = out_valid_q;
    out_rs1_val_d = out_rs1_val_q;
    out_rs2_val_d = out_rs2_val_q;
    out_rd_d      = out_rd_q;
    out_rd_we_d   = out_rd_we_q;
    if (flush) begin
      out_valid_d = 1'b0;
    end else if (accept) begin
      out_valid_d   = 1'b1;
      out_rs1_val_d = src1_val;
      out_rs2_val_d = src2_val;
      out_rd_d      = in_rd;
      out_rd_we_d   = in_rd_we;
    end else if (out_ready) begin
      out_valid_d = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_valid_q   <= 1'b0;
      out_rs1_val_q <= '0;
      out_rs2_val_q <= '0;
      out_rd_q      <= '0;
      out_rd_we_q   <= 1'b0;
    end else begin
      out_valid_q   <= out_valid_d;
      out_rs1_val_q <= out_rs1_val_d;
      out_rs2_val_q <= out_rs2_val_d;
      out_rd_q      <= out_rd_d;
      out_rd_we_q   <= out_rd_we_d;
    end
  end

  assign out_valid   = out_valid_q;
  assign out_rs1_val = out_rs1_val_q;
  assign out_rs2_val = out_rs2_val_q;
  assign out_rd      = out_rd_q;
  assign out_rd_we   = out_rd_we_q;

endmodule

// File: tb/tb_operand_fetch.sv
// Bench for operand_fetch: a register-file model plus a busy/valid reference model;
// expected operand entries are queued at issue and compared when execute sees them.
module tb_operand_fetch;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        flush = 1'b0;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [4:0]  in_rs1 = '0, in_rs2 = '0, in_rd = '0;
  logic        in_rd_we = 1'b0;
  logic [4:0]  rf_addr1, rf_addr2;
  logic [31:0] rf_rd1, rf_rd2;
  logic        wb_we = 1'b0;
  logic [4:0]  wb_addr = '0;
  logic [31:0] wb_data = '0;
  logic        out_valid;
  logic        out_ready = 1'b1;
  logic [31:0] out_rs1_val, out_rs2_val;
  logic [4:0]  out_rd;
  logic        out_rd_we;

  always #5 clk = ~clk;

  operand_fetch dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .flush       (flush),
    .in_valid    (in_valid),
    .in_ready    (in_ready),
    .in_rs1      (in_rs1),
    .in_rs2      (in_rs2),
    .in_rd       (in_rd),
    .in_rd_we    (in_rd_we),
    .rf_addr1    (rf_addr1),
    .rf_addr2    (rf_addr2),
    .rf_rd1      (rf_rd1),
    .rf_rd2      (rf_rd2),
    .wb_we       (wb_we),
    .wb_addr     (wb_addr),
    .wb_data     (wb_data),
    .out_valid   (out_valid),
    .out_ready   (out_ready),
    .out_rs1_val (out_rs1_val),
    .out_rs2_val (out_rs2_val),
    .out_rd      (out_rd),
    .out_rd_we   (out_rd_we)
  );

  // Register file environment: combinational read, written by writeback at the edge.
  logic [31:0] rf_mem [32];
  assign rf_rd1 = (rf_addr1 == 5'd0) ? 32'd0 : rf_mem[rf_addr1];
  assign rf_rd2 = (rf_addr2 == 5'd0) ? 32'd0 : rf_mem[rf_addr2];
  always @(posedge clk) begin
    if (wb_we && wb_addr != 5'd0) rf_mem[wb_addr] <= wb_data;
  end

  typedef struct packed {
    logic [31:0] v1;
    logic [31:0] v2;
    logic [4:0]  rd;
    logic        we;
  } exp_t;

  exp_t sbq[$];
  bit   mbusy [32];
  bit   mv;
  int   n_checks = 0;
  int   n_errors = 0;

  task automatic check_val(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, obs, exp, $time);
    end
  endtask

  function automatic bit hz(input logic [4:0] i);
    return (i != 5'd0) && mbusy[i] && !(wb_we && wb_addr == i);
  endfunction

  function automatic bit model_ready();
    return (!mv || out_ready) && !hz(in_rs1) && !hz(in_rs2) && !(in_rd_we && hz(in_rd)) && !flush;
  endfunction

  function automatic logic [31:0] byp(input logic [4:0] i);
    if (i == 5'd0) return 32'd0;
    if (wb_we && wb_addr == i) return wb_data;
    return rf_mem[i];
  endfunction

  task automatic model_reset();
    sbq.delete();
    mv = 1'b0;
    for (int i = 0; i < 32; i++) mbusy[i] = 1'b0;
  endtask

  task automatic check_reset_outs();
    check_val("rst_out_valid", out_valid, 0);
    check_val("rst_out_rs1_val", out_rs1_val, 0);
    check_val("rst_out_rs2_val", out_rs2_val, 0);
    check_val("rst_out_rd", out_rd, 0);
    check_val("rst_out_rd_we", out_rd_we, 0);
  endtask

  // One clock: inputs already driven just after a falling edge.
  task automatic tick();
    exp_t e;
    bit   rdy, acc;
    #2;
    rdy = model_ready();
    check_val("in_ready", in_ready, rdy);
    check_val("rf_addr1", rf_addr1, in_rs1);
    check_val("out_valid", out_valid, mv);
    if (mv) begin
      if (sbq.size() == 0) begin
        check_val("sb_depth", sbq.size(), 1);
      end else begin
        check_val("out_rs1_val", out_rs1_val, sbq[0].v1);
        check_val("out_rs2_val", out_rs2_val, sbq[0].v2);
        check_val("out_rd", out_rd, sbq[0].rd);
        check_val("out_rd_we", out_rd_we, sbq[0].we);
        if (out_ready) void'(sbq.pop_front());
      end
    end
    acc = in_valid && rdy;
    if (acc) begin
      e.v1 = byp(in_rs1);
      e.v2 = byp(in_rs2);
      e.rd = in_rd;
      e.we = in_rd_we;
      sbq.push_back(e);
    end
    @(posedge clk);
    if (flush) begin
      if (mv && !out_ready && sbq.size() > 0) void'(sbq.pop_front());
      mv = 1'b0;
      for (int i = 0; i < 32; i++) mbusy[i] = 1'b0;
    end else begin
      if (acc) mv = 1'b1;
      else if (out_ready) mv = 1'b0;
      if (wb_we && wb_addr != 5'd0) mbusy[wb_addr] = 1'b0;
      if (acc && in_rd_we && in_rd != 5'd0) mbusy[in_rd] = 1'b1;
    end
    @(negedge clk);
  endtask

  task automatic set_in(input bit v, input logic [4:0] rs1, input logic [4:0] rs2,
                        input logic [4:0] rd, input bit we);
    in_valid = v;
    in_rs1   = rs1;
    in_rs2   = rs2;
    in_rd    = rd;
    in_rd_we = we;
  endtask

  task automatic set_wb(input bit we, input logic [4:0] a, input logic [31:0] d);
    wb_we   = we;
    wb_addr = a;
    wb_data = d;
  endtask

  task automatic idle();
    set_in(0, 0, 0, 0, 0);
    set_wb(0, 0, 0);
    flush     = 1'b0;
    out_ready = 1'b1;
  endtask

  initial begin
    model_reset();
    #3;
    check_reset_outs();
    @(negedge clk);
    rst_n = 1'b1;
    idle();

    // Preload the register file through writeback; nothing is pending yet.
    for (int i = 1; i < 16; i++) begin
      set_wb(1, 5'(i), 32'h0101_0000 + 32'(i));
      tick();
    end
    set_wb(1, 5, 32'h1234);       tick();
    set_wb(1, 6, 32'hABCD);       tick();
    set_wb(1, 7, 32'h11);         tick();
    idle();

    // Basic read
    set_in(1, 5, 6, 1, 0); tick();
    idle(); tick();

    // x0 is never bypassed; real register bypasses stale rf data
    set_in(1, 0, 5, 0, 0); set_wb(1, 0, 32'hFFFF); tick();
    set_in(1, 0, 7, 0, 0); set_wb(1, 7, 32'h55);   tick();
    idle(); tick();

    // RAW stall on x3 until its writeback, which is bypassed
    set_in(1, 1, 2, 3, 1); tick();
    set_in(1, 3, 0, 0, 0); tick(); tick(); tick();
    set_wb(1, 3, 32'h99); tick();
    set_wb(0, 0, 0);      tick();
    idle(); tick();

    // Back-pressure: held operands ignore later writebacks to their source
    set_in(1, 8, 2, 0, 0); tick();
    out_ready = 1'b0;
    set_in(1, 10, 0, 0, 0);
    tick();
    set_wb(1, 8, 32'hDEAD); tick();
    set_wb(0, 0, 0);        tick(); tick();
    out_ready = 1'b1; tick();
    idle(); tick();

    // WAW on x4: accept coinciding with x4 writeback leaves x4 pending
    set_in(1, 1, 2, 4, 1); tick();
    tick();
    set_wb(1, 4, 32'h44); tick();
    set_wb(0, 0, 0);
    set_in(1, 4, 0, 0, 0); tick(); tick();
    set_wb(1, 4, 32'h4444); tick();
    idle(); tick();

    // Flush with a held output and x9 pending
    set_in(1, 1, 0, 9, 1); tick();
    out_ready = 1'b0;
    set_in(1, 9, 0, 0, 0); tick();
    flush = 1'b1; tick();
    flush = 1'b0; out_ready = 1'b1; tick();
    idle(); tick();

    // Asynchronous reset while stalled
    set_in(1, 2, 3, 12, 1); tick();
    out_ready = 1'b0;
    set_in(1, 12, 0, 0, 0); tick();
    #2;
    rst_n = 1'b0;
    #1;
    check_reset_outs();
    model_reset();
    @(negedge clk);
    rst_n = 1'b1;
    out_ready = 1'b1;
    tick();
    idle(); tick();

    // Random traffic over a small register window
    for (int n = 0; n < 300; n++) begin
      set_in(1'($urandom_range(0, 1)), 5'($urandom_range(0, 7)), 5'($urandom_range(0, 7)),
             5'($urandom_range(0, 7)), 1'($urandom_range(0, 1)));
      set_wb(1'($urandom_range(0, 2) == 0), 5'($urandom_range(0, 7)), $urandom);
      out_ready = ($urandom_range(0, 3) != 0);
      flush     = ($urandom_range(0, 24) == 0);
      tick();
    end
    idle(); tick(); tick();

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
